// File: rtl/apb_bus_arbiter.sv
// rtl/apb_bus_arbiter.sv - two-port round-robin arbiter in front of the APB master request interface
module apb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        PCLK,
  input  logic        PRESET,
  // requester port 0
  input  logic        s0_transfer,
  input  logic        s0_write,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  output logic        s0_ready,
  output logic [31:0] s0_rdata,
  // requester port 1
  input  logic        s1_transfer,
  input  logic        s1_write,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  output logic        s1_ready,
  output logic [31:0] s1_rdata,
  // APB master request interface
  output logic        m_transfer,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  // status
  output logic        grant,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] WD_MAX        = 16'hFFFF;

  state_t      state_q, state_d;

  // pending request buffers
  logic        v0_q, v0_d;
  logic        w0_q, w0_d;
  logic [31:0] a0_q, a0_d;
  logic [31:0] d0_q, d0_d;
  logic        v1_q, v1_d;
  logic        w1_q, w1_d;
  logic [31:0] a1_q, a1_d;
  logic [31:0] d1_q, d1_d;

  // arbitration and issued request
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        m_transfer_q, m_transfer_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;

  // responses and status
  logic        s0_ready_q, s0_ready_d;
  logic        s1_ready_q, s1_ready_d;
  logic [31:0] s0_rdata_q, s0_rdata_d;
  logic [31:0] s1_rdata_q, s1_rdata_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wd_q, wd_d;

  logic        resp_cycle;
  logic        sel;

  assign resp_cycle = (state_q == ST_RESP);

  // port 1 wins only if it is the sole requester or port 0 was served last
  assign sel = v1_q && (!v0_q || !last_grant_q);

  // Pending buffers: a request is taken when the buffer is empty, or during the
  // granted port's RESP cycle so that a back-to-back request is not lost
  always_comb begin
    v0_d = v0_q;
    w0_d = w0_q;
    a0_d = a0_q;
    d0_d = d0_q;
    v1_d = v1_q;
    w1_d = w1_q;
    a1_d = a1_q;
    d1_d = d1_q;

    if (resp_cycle && !grant_q) begin
      v0_d = 1'b0;
    end
    if (resp_cycle && grant_q) begin
      v1_d = 1'b0;
    end

    if (s0_transfer && (!v0_q || (resp_cycle && !grant_q))) begin
      v0_d = 1'b1;
      w0_d = s0_write;
      a0_d = s0_addr;
      d0_d = s0_wdata;
    end
    if (s1_transfer && (!v1_q || (resp_cycle && grant_q))) begin
      v1_d = 1'b1;
      w1_d = s1_write;
      a1_d = s1_addr;
      d1_d = s1_wdata;
    end
  end

  // Transaction sequencing, response routing and watchdog; outputs follow the next state
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_write_d    = m_write_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    s0_rdata_d   = s0_rdata_q;
    s1_rdata_d   = s1_rdata_q;
    wd_d         = wd_q;
    timeout_d    = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (v0_q || v1_q) begin
          state_d      = ST_SETUP;
          grant_d      = sel;
          last_grant_d = sel;
          m_write_d    = sel ? w1_q : w0_q;
          m_addr_d     = sel ? a1_q : a0_q;
          m_wdata_d    = sel ? d1_q : d0_q;
          wd_d         = 16'd0;
        end
      end
      ST_SETUP: begin
        if (m_ready) begin
          state_d = ST_RESP;
          if (grant_q) begin
            s1_rdata_d = m_rdata;
          end else begin
            s0_rdata_d = m_rdata;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wd_q != WD_MAX) begin
          wd_d = wd_q + 16'd1;
        end
        if (m_ready) begin
          state_d = ST_RESP;
          if (grant_q) begin
            s1_rdata_d = m_rdata;
          end else begin
            s0_rdata_d = m_rdata;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // the flag is sticky; the stalled transaction keeps waiting
    if (wd_d == TIMEOUT_LIMIT) begin
      timeout_d = 1'b1;
    end

    m_transfer_d = (state_d == ST_SETUP);
    busy_d       = (state_d != ST_IDLE);
    s0_ready_d   = (state_d == ST_RESP) && !grant_d;
    s1_ready_d   = (state_d == ST_RESP) && grant_d;
  end

  // State register with asynchronous reset that drops any in-flight or pending work
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q      <= ST_IDLE;
      v0_q         <= 1'b0;
      w0_q         <= 1'b0;
      a0_q         <= 32'd0;
      d0_q         <= 32'd0;
      v1_q         <= 1'b0;
      w1_q         <= 1'b0;
      a1_q         <= 32'd0;
      d1_q         <= 32'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_transfer_q <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= 32'd0;
      m_wdata_q    <= 32'd0;
      s0_ready_q   <= 1'b0;
      s1_ready_q   <= 1'b0;
      s0_rdata_q   <= 32'd0;
      s1_rdata_q   <= 32'd0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= 16'd0;
    end else begin
      state_q      <= state_d;
      v0_q         <= v0_d;
      w0_q         <= w0_d;
      a0_q         <= a0_d;
      d0_q         <= d0_d;
      v1_q         <= v1_d;
      w1_q         <= w1_d;
      a1_q         <= a1_d;
      d1_q         <= d1_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_transfer_q <= m_transfer_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      s0_ready_q   <= s0_ready_d;
      s1_ready_q   <= s1_ready_d;
      s0_rdata_q   <= s0_rdata_d;
      s1_rdata_q   <= s1_rdata_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
    end
  end

  assign s0_ready   = s0_ready_q;
  assign s0_rdata   = s0_rdata_q;
  assign s1_ready   = s1_ready_q;
  assign s1_rdata   = s1_rdata_q;
  assign m_transfer = m_transfer_q;
  assign m_write    = m_write_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule
